// File: rtl/data_mem_pkg.sv
// Shared size encodings, FSM state type and byte-lane mask helper for the wait-state data memory.
package data_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  // Byte enables for an access of the given size starting at the given lane.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      SIZE_BYTE: m = 4'b0001 << lane;
      SIZE_HALF: m = 4'b0011 << lane;
      SIZE_WORD: m = 4'b1111;
      default:   m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables, replicated write data and extended read value.
// No state, zero latency; the caller decides when the results are used.
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rval
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    be    = lane_mask(size, lane);
    rbyte = rword[{lane, 3'b000} +: 8];
    rhalf = rword[{lane[1], 4'b0000} +: 16];
    wword = wdata;
    rval  = rword;
    case (size)
      SIZE_BYTE: begin
        wword = {4{wdata[7:0]}};
        rval  = {{24{sign_ext & rbyte[7]}}, rbyte};
      end
      SIZE_HALF: begin
        wword = {2{wdata[15:0]}};
        rval  = {{16{sign_ext & rhalf[15]}}, rhalf};
      end
      default: begin
        wword = wdata;
        rval  = rword;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_ws.sv
// MEM-stage data memory with programmable wait states; ready pulses WAIT_STATES+1 cycles after accept.
// Requests are sampled only in IDLE, so a held request simply stalls until the access completes.
module data_memory_ws
  import data_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LIMIT    = ADDR_W'(DEPTH);
  localparam logic [3:0]        CNT_INIT = 4'(WAIT_STATES - 1);

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       finish;

  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;
  logic              sext_q, rd_q, wr_q;

  logic [ADDR_W-1:0] e_addr;
  logic [31:0]       e_wdata;
  logic [1:0]        e_size;
  logic              e_sext, e_rd, e_wr;

  logic [ADDR_W-1:0] off;
  logic [1:0]        lane;
  logic [IDX_W-1:0]  idx;
  logic              bad_range, bad_align, acc_err;

  logic [31:0] mem [DEPTH];
  logic [31:0] rword, wword, rval;
  logic [3:0]  be;

  logic [31:0] rdata_q;
  logic        err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_read || mem_write) begin
          if (WAIT_STATES == 0) begin
            state_nxt = DONE;
            finish    = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = DONE;
          finish    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else if (state == IDLE && (mem_read || mem_write)) begin
      addr_q  <= addr;
      wdata_q <= wdata;
      size_q  <= size;
      sext_q  <= sign_ext;
      rd_q    <= mem_read;
      wr_q    <= mem_write;
    end
  end

  // With zero wait states the access completes on the accept edge, so use the live request.
  always_comb begin
    if (state == IDLE) begin
      e_addr  = addr;
      e_wdata = wdata;
      e_size  = size;
      e_sext  = sign_ext;
      e_rd    = mem_read;
      e_wr    = mem_write;
    end else begin
      e_addr  = addr_q;
      e_wdata = wdata_q;
      e_size  = size_q;
      e_sext  = sext_q;
      e_rd    = rd_q;
      e_wr    = wr_q;
    end
  end

  assign off       = e_addr - BASE;
  assign lane      = off[1:0];
  assign idx       = off[IDX_W+1:2];
  assign bad_range = (e_addr < BASE) || ((off >> 2) >= LIMIT);
  assign bad_align = ((e_size == SIZE_HALF) && lane[0]) ||
                     ((e_size == SIZE_WORD) && (lane != 2'b00));
  assign acc_err   = bad_range || (e_size == 2'b11) || bad_align || (e_rd && e_wr);

  assign rword = mem[idx];

  mem_lane_align u_align (
    .lane     (lane),
    .size     (e_size),
    .sign_ext (e_sext),
    .wdata    (e_wdata),
    .rword    (rword),
    .be       (be),
    .wword    (wword),
    .rval     (rval)
  );

  // The array has no reset; rst only suppresses a write that would land on the same edge.
  always_ff @(posedge clk) begin
    if (!rst && finish && e_wr && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (finish) begin
      err_q <= acc_err;
      if (e_rd && !acc_err) rdata_q <= rval;
    end
  end

  assign rdata = rdata_q;
  assign ready = (state == DONE);
  assign busy  = (state != IDLE);
  assign err   = ready & err_q;

endmodule
